instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Program buffer and issue stage placed directly upstream of the compute unit. It holds a short program of 16-bit instructions, each made of an opcode/destination byte and an operand byte. When started, it replays the program one instruction per enabled cycle onto the compute unit's `ui_in`/`uio_in` buses. This lets the compute unit run multi-instruction sequences without the host driving every cycle.

## Interface
Parameters:
- `DEPTH`, 8: program entries; must be a power of two.
- `ADDR_W`, 3: log2(`DEPTH`).

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ena`  in  1  global enable; low freezes all state, including memory writes.
- `wr_en`  in  1  program write strobe.
- `wr_addr`  in  `ADDR_W`  program write address.
- `wr_data`  in  16  instruction; [15:8] goes to `cu_ui`, [7:0] goes to `cu_uio`.
- `start`  in  1  begin execution at entry 0.
- `stop`  in  1  abort execution.
- `loop_en`  in  1  wrap from the last entry back to 0 instead of finishing.
- `cu_ui`  out  8  instruction byte to the compute unit `ui_in`.
- `cu_uio`  out  8  operand byte to the compute unit `uio_in`.
- `issue_valid`  out  1  `cu_ui`/`cu_uio` carry an instruction this cycle.
- `busy`  out  1  state is RUN.
- `done`  out  1  state is DONE.
- `wr_err`  out  1  one-cycle pulse when a write is attempted while in RUN.
- `pc`  out  `ADDR_W`  next entry to issue.

## Operation
- States: IDLE, RUN, DONE.
- Opcodes: opcode = instruction[15:12]. `4'hF` = END. `4'h0` = NOP, which is issued normally.
- Program memory: `DEPTH` × 16 flops.
  - Synchronous write when `wr_en & ena & state!=RUN`.
  - Asynchronous read at `pc`.
- IDLE:
  - `cu_ui`, `cu_uio`, `issue_valid` are 0.
  - `start` → RUN with `pc`=0.
- RUN, each `ena` cycle:
  - Fetch `mem[pc]`.
  - If opcode == END → DONE; outputs cleared; `issue_valid`=0.
  - Otherwise register the instruction onto `cu_ui`/`cu_uio`, set `issue_valid`=1, and increment `pc`.
- Last entry (`pc`==`DEPTH`-1) issued and not END:
  - `loop_en`=1 → `pc` wraps to 0 and the sequencer stays in RUN.
  - `loop_en`=0 → DONE on the following cycle, with no further issue.
- `stop` in RUN → IDLE. The next edge clears the outputs; `pc` is held.
- `start` and `stop` in the same cycle: `stop` wins.
- DONE:
  - `done`=1, outputs are 0.
  - `start` → RUN from `pc`=0.
  - `stop` → IDLE.
- `start` while already in RUN is ignored.
- `wr_en` while in RUN: memory is unchanged and `wr_err` pulses for one cycle.
- `ena`=0: every register holds, including `issue_valid`. The compute unit is gated by the same `ena`.

## Timing
- Reset values: state=IDLE, `pc`=0, all memory=0 (NOP), `cu_ui`=`cu_uio`=0, `issue_valid`=`busy`=`done`=`wr_err`=0.
- `start` sampled at edge E0 → `busy`=1 after E0.
- `mem[0]` appears on the outputs after E1, then one instruction per enabled edge.
- With a program of N non-END entries followed by END: issues occur after E1..EN. After E(N+1), `issue_valid`=0 and `done`=1.
- Write-to-issue: a written entry is visible to a `start` given on the next cycle.
- `rst` asserted mid-RUN: all registers and memory clear immediately (asynchronously) to reset values.

## Configuration
- `INSTR_SEQUENCER_STEP_EN` defined:
  - Adds input port `step` (1 bit).
  - In RUN, a fetch/issue happens only on cycles with `step & ena`.
  - On other RUN cycles, `issue_valid`=0 and `pc` holds.
  - END detection also waits for `step`.
- Undefined: no `step` port; RUN issues every `ena` cycle.

## Structure
- Package `instr_sequencer_pkg`:
  - state enum `seq_state_t` (IDLE, RUN, DONE).
  - `OP_END`=4'hF, `OP_NOP`=4'h0.
  - `INSTR_W`=16.
- Sub-module `seq_prog_mem`:
  - `DEPTH`×16 register file.
  - async-reset clear, gated synchronous write, combinational read.
- The top level holds the FSM, `pc` counter and output registers.

## Test plan
- Load entries 0..3 = 0x1048, 0x1181, 0x2201, 0xF000, then pulse `start` → `cu_ui`/`cu_uio` show 0x10/0x48, 0x11/0x81, 0x22/0x01 on three consecutive cycles with `issue_valid`=1; the next cycle has `issue_valid`=0 and `done`=1.
- All 8 entries = 0x1101 with `loop_en`=1 → continuous issue; `pc` wraps 7→0; `done` stays 0. Pulse `stop` → IDLE one cycle later, outputs 0.
- Same program with `loop_en`=0 → exactly 8 issues, then `done`=1.
- `wr_en` with `wr_addr`=2, `wr_data`=0xFFFF during RUN → `wr_err` pulses for one cycle; the third issue is still the original entry.
- Toggle `ena` low for 3 cycles mid-RUN → outputs and `pc` frozen, then issue resumes with no skipped entry.
- Assert `rst` between edges during RUN → outputs drop to 0 immediately. A subsequent `start` issues 0x00/0x00 (NOP) eight times, then `done`=1.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// instr_sequencer_pkg
//   Shared types and constants for the instruction sequencer slice:
//   sequencer state enum, instruction width and the opcodes the sequencer
//   itself interprets (END terminates a program, NOP is issued like any other).
// -----------------------------------------------------------------------------
package instr_sequencer_pkg;

    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_END = 4'hF;
    localparam logic [3:0] OP_NOP = 4'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Opcode lives in the top nibble of the instruction byte.
    function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: 4];
    endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// -----------------------------------------------------------------------------
// seq_prog_mem
//   DEPTH x INSTR_W program register file with asynchronous clear,
//   synchronous gated write and combinational read.
//
//   clk    in   clock
//   rst    in   asynchronous active-high clear of every entry (to NOP)
//   we     in   write strobe (already qualified by enable and FSM state)
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  mem[raddr], combinational
// -----------------------------------------------------------------------------
module seq_prog_mem
    import instr_sequencer_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [DEPTH];

    // NOTE: this array is built from flops, so it may (and must) be reset;
    // an SRAM macro could not be cleared this way.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//   Program buffer and issue stage feeding the compute unit. Holds a short
//   program and, once started, replays one instruction per enabled cycle onto
//   cu_ui / cu_uio until an END opcode, the last entry (loop_en=0) or stop.
//
//   Optional build macro INSTR_SEQUENCER_STEP_EN: adds a 'step' input; in RUN
//   a fetch/issue (and END detection) only happens on step & ena cycles.
//
//   clk, rst       clock, asynchronous active-high reset
//   ena            global enable; low freezes every register and the memory
//   wr_en/addr/data program write port (refused while running -> wr_err)
//   start/stop     begin at entry 0 / abort (stop wins)
//   loop_en        wrap from the last entry back to 0
//   cu_ui, cu_uio  instruction / operand bytes to the compute unit
//   issue_valid    cu_ui/cu_uio carry an instruction this cycle
//   busy, done     state is RUN / DONE
//   wr_err         one-cycle pulse for a write attempted while running
//   pc             next entry to issue
// -----------------------------------------------------------------------------
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
`ifdef INSTR_SEQUENCER_STEP_EN
    input  logic               step,
`endif
    output logic [7:0]         cu_ui,
    output logic [7:0]         cu_uio,
    output logic               issue_valid,
    output logic               busy,
    output logic               done,
    output logic               wr_err,
    output logic [ADDR_W-1:0]  pc
);

    seq_state_t         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [7:0]         ui_q, ui_d, uio_q, uio_d;
    logic               valid_q, valid_d;
    logic               wr_err_q, wr_err_d;
    // Set after the last entry issues with loop_en low: the next fetch slot
    // ends the program instead of issuing entry 0 again.
    logic               finish_q, finish_d;
    logic               fetch_ok;
    logic [INSTR_W-1:0] rd_instr;

`ifdef INSTR_SEQUENCER_STEP_EN
    assign fetch_ok = step;
`else
    assign fetch_ok = 1'b1;
`endif

    seq_prog_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en && ena && (state_q != RUN)),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (pc_q),
        .rdata (rd_instr)
    );

    // NOTE: every signal is given a hold/default value before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ui_d     = ui_q;
        uio_d    = uio_q;
        valid_d  = valid_q;
        finish_d = finish_q;
        wr_err_d = wr_en && (state_q == RUN);

        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d  = RUN;
                    pc_d     = '0;
                    finish_d = 1'b0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d  = IDLE;
                    ui_d     = {OP_NOP, 4'h0};
                    uio_d    = '0;
                    valid_d  = 1'b0;
                    finish_d = 1'b0;
                end else if (fetch_ok) begin
                    if (finish_q || opcode_of(rd_instr) == OP_END) begin
                        state_d  = DONE;
                        ui_d     = {OP_NOP, 4'h0};
                        uio_d    = '0;
                        valid_d  = 1'b0;
                        finish_d = 1'b0;
                    end else begin
                        ui_d     = rd_instr[15:8];
                        uio_d    = rd_instr[7:0];
                        valid_d  = 1'b1;
                        pc_d     = pc_q + 1'b1;  // wraps to 0 after the last entry
                        finish_d = (pc_q == ADDR_W'(DEPTH - 1)) && !loop_en;
                    end
                end else begin
                    valid_d = 1'b0;
                end
            end
            DONE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d  = RUN;
                    pc_d     = '0;
                    finish_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            ui_q     <= '0;
            uio_q    <= '0;
            valid_q  <= 1'b0;
            wr_err_q <= 1'b0;
            finish_q <= 1'b0;
        end else if (ena) begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ui_q     <= ui_d;
            uio_q    <= uio_d;
            valid_q  <= valid_d;
            wr_err_q <= wr_err_d;
            finish_q <= finish_d;
        end
    end

    assign cu_ui       = ui_q;
    assign cu_uio      = uio_q;
    assign issue_valid = valid_q;
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign wr_err      = wr_err_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
//   Self-checking bench for instr_sequencer (default build). A behavioural
//   model of the sequencer is compared against the DUT on every falling edge;
//   directed scenarios add literal expectations, then a randomized phase runs.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic [7:0]  cu_ui, cu_uio;
    logic        issue_valid, busy, done, wr_err;
    logic [2:0]  pc;

    int n_checks = 0;
    int n_errors = 0;

    instr_sequencer #(.DEPTH(DEPTH), .ADDR_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .stop        (stop),
        .loop_en     (loop_en),
        .cu_ui       (cu_ui),
        .cu_uio      (cu_uio),
        .issue_valid (issue_valid),
        .busy        (busy),
        .done        (done),
        .wr_err      (wr_err),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
    logic [15:0] m_prog [DEPTH];
    int          m_mode;
    int          m_pc;
    logic [15:0] m_out;
    bit          m_valid, m_wr_err, m_finishing;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            foreach (m_prog[i]) m_prog[i] = 16'h0000;
            m_mode = M_IDLE; m_pc = 0; m_out = 0;
            m_valid = 0; m_wr_err = 0; m_finishing = 0;
        end else if (ena) begin
            bit can_write;
            can_write = wr_en && (m_mode != M_RUN);
            m_wr_err  = wr_en && (m_mode == M_RUN);
            if (m_mode == M_RUN) begin
                if (stop) begin
                    m_mode = M_IDLE; m_out = 0; m_valid = 0; m_finishing = 0;
                end else if (m_finishing || m_prog[m_pc][15:12] == 4'hF) begin
                    m_mode = M_DONE; m_out = 0; m_valid = 0; m_finishing = 0;
                end else begin
                    m_out       = m_prog[m_pc];
                    m_valid     = 1;
                    m_finishing = (m_pc == DEPTH - 1) && !loop_en;
                    m_pc        = (m_pc + 1) % DEPTH;
                end
            end else if (stop) begin
                m_mode = M_IDLE;
            end else if (start) begin
                m_mode = M_RUN; m_pc = 0; m_finishing = 0;
            end
            if (can_write) m_prog[wr_addr] = wr_data;
        end
    end

    // Compare process: outputs settle after the rising edge, sampled on the falling one.
    always @(negedge clk) begin
        check("cu_ui",       32'(cu_ui),       32'(m_out[15:8]));
        check("cu_uio",      32'(cu_uio),      32'(m_out[7:0]));
        check("issue_valid", 32'(issue_valid), 32'(m_valid));
        check("busy",        32'(busy),        32'(m_mode == M_RUN));
        check("done",        32'(done),        32'(m_mode == M_DONE));
        check("wr_err",      32'(wr_err),      32'(m_wr_err));
        check("pc",          32'(pc),          32'(m_pc));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic write_entry(input int addr, input logic [15:0] data);
        wr_en = 1'b1; wr_addr = 3'(addr); wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
        $fatal(1);
    end

    initial begin
        int issues, nops;
        bit saw_wrap, saw_done;
        logic [2:0] prev_pc, held_pc;
        logic [7:0] held_ui;

        tick(); tick();
        rst = 1'b0;
        tick();
        check("reset_busy",  32'(busy), 32'd0);
        check("reset_valid", 32'(issue_valid), 32'd0);
        check("reset_pc",    32'(pc), 32'd0);

        // Short program ending in END
        write_entry(0, 16'h1048);
        write_entry(1, 16'h1181);
        write_entry(2, 16'h2201);
        write_entry(3, 16'hF000);
        pulse_start();
        check("start_busy", 32'(busy), 32'd1);
        tick();
        check("p1_issue0", {16'h0, cu_ui, cu_uio}, 32'h1048);
        check("p1_valid0", 32'(issue_valid), 32'd1);
        tick();
        check("p1_issue1", {16'h0, cu_ui, cu_uio}, 32'h1181);
        tick();
        check("p1_issue2", {16'h0, cu_ui, cu_uio}, 32'h2201);
        tick();
        check("p1_end_valid", 32'(issue_valid), 32'd0);
        check("p1_end_done",  32'(done), 32'd1);

        // Looping program, then stop
        for (int i = 0; i < DEPTH; i++) write_entry(i, 16'h1101);
        loop_en = 1'b1;
        pulse_start();
        saw_wrap = 0; saw_done = 0; prev_pc = pc;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (prev_pc == 3'd7 && pc == 3'd0 && issue_valid) saw_wrap = 1;
            if (done) saw_done = 1;
            prev_pc = pc;
        end
        check("loop_wrap", 32'(saw_wrap), 32'd1);
        check("loop_no_done", 32'(saw_done), 32'd0);
        pulse_stop();
        check("stop_busy",  32'(busy), 32'd0);
        check("stop_valid", 32'(issue_valid), 32'd0);
        check("stop_out",   {16'h0, cu_ui, cu_uio}, 32'h0);

        // Same program without looping: exactly 8 issues
        loop_en = 1'b0;
        pulse_start();
        issues = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (issue_valid) issues++;
        end
        check("noloop_issues", 32'(issues), 32'd8);
        check("noloop_done", 32'(done), 32'd1);

        // Write during RUN is refused
        for (int i = 0; i < DEPTH; i++) write_entry(i, 16'h1000 | 16'(i << 8) | 16'(i));
        pulse_start();
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hFFFF;
        tick();
        wr_en = 1'b0;
        check("wr_err_pulse", 32'(wr_err), 32'd1);
        tick();
        check("wr_err_clear", 32'(wr_err), 32'd0);
        tick();
        check("wr_keep_entry2", {16'h0, cu_ui, cu_uio}, 32'h1202);
        for (int i = 0; i < 10; i++) tick();

        // Enable low for three cycles mid-run
        pulse_start();
        tick(); tick();
        ena = 1'b0;
        held_pc = pc; held_ui = cu_ui;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frozen_pc", 32'(pc), 32'(held_pc));
            check("frozen_ui", 32'(cu_ui), 32'(held_ui));
        end
        ena = 1'b1;
        tick();
        check("resume_ui", 32'(cu_ui), 32'(8'h10 | 8'(held_pc)));

        // Asynchronous reset between edges
        tick();
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(issue_valid), 32'd0);
        check("arst_out",   {16'h0, cu_ui, cu_uio}, 32'h0);
        check("arst_busy",  32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        pulse_start();
        issues = 0; nops = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (issue_valid) begin
                issues++;
                if (cu_ui == 8'h00 && cu_uio == 8'h00) nops++;
            end
        end
        check("arst_nop_issues", 32'(issues), 32'd8);
        check("arst_nop_values", 32'(nops), 32'd8);
        check("arst_done", 32'(done), 32'd1);

        // Randomized phase against the model
        for (int cyc = 0; cyc < 4000; cyc++) begin
            ena     = ($urandom_range(0, 9) != 0);
            wr_en   = ($urandom_range(0, 9) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 16'($urandom);
            if ($urandom_range(0, 5) == 0) wr_data[15:12] = 4'hF;
            start   = ($urandom_range(0, 11) == 0);
            stop    = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 49) == 0) loop_en = ~loop_en;
            if ($urandom_range(0, 999) == 0) begin
                #2 rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end
        wr_en = 1'b0; start = 1'b0; stop = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
